// File: rtl/resize_interp_engine_pkg.sv
// Shared widths, FSM state encoding and the latched request record for the resize interpolation engine.
package resize_interp_engine_pkg;

   localparam int ADDR_SZ = 16;
   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD1  = 3'd1,
      ST_RD2  = 3'd2,
      ST_CAP  = 3'd3,
      ST_CALC = 3'd4,
      ST_WR   = 3'd5
   } state_e;

   typedef struct packed {
      logic [ADDR_SZ-1:0] src_addr1;
      logic [ADDR_SZ-1:0] src_addr2;
      logic [ADDR_SZ-1:0] des_addr;
      logic [FRAC_W-1:0]  frac;
      logic               stage;
   } req_t;

endpackage

// File: rtl/resize_interp_engine_if.sv
// Request handshake from the resize controller and the pixel RAM port, with a modport for each side.
interface resize_interp_engine_if;
   import resize_interp_engine_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [ADDR_SZ-1:0] src_addr1;
   logic [ADDR_SZ-1:0] src_addr2;
   logic [ADDR_SZ-1:0] des_addr;
   logic [FRAC_W-1:0]  fraction_part;
   logic               stage_flag;

   logic               rd_en;
   logic [ADDR_SZ-1:0] rd_addr;
   logic [DATA_W-1:0]  rd_data;
   logic               wr_en;
   logic [ADDR_SZ-1:0] wr_addr;
   logic [DATA_W-1:0]  wr_data;
   logic               wr_stage;

   modport req_master (output req_valid, src_addr1, src_addr2, des_addr, fraction_part, stage_flag,
                       input  req_ready);
   modport req_slave  (input  req_valid, src_addr1, src_addr2, des_addr, fraction_part, stage_flag,
                       output req_ready);
   modport ram_master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_stage,
                       input  rd_data);
   modport ram_slave  (input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_stage,
                       output rd_data);

endinterface

// File: rtl/resize_interp_engine_lerp.sv
// Combinational 1-D lerp: p1 + ((p2 - p1) * frac >>> FRAC_W).
// Defining RESIZE_ROUND_EN rounds half-up instead of truncating toward minus infinity.
module resize_interp_engine_lerp
   import resize_interp_engine_pkg::*;
(
   input  logic [DATA_W-1:0] p1_i,
   input  logic [DATA_W-1:0] p2_i,
   input  logic [FRAC_W-1:0] frac_i,
   output logic [DATA_W-1:0] result_o
);

   localparam int PROD_W = DATA_W + FRAC_W + 2;

   logic signed [DATA_W:0]   diff_s;
   logic signed [PROD_W-1:0] prod_s;
   logic signed [PROD_W-1:0] adj_s;
   logic signed [PROD_W-1:0] shifted_s;
   logic signed [PROD_W-1:0] sum_s;
   logic                     unused_hi_s;

   assign diff_s = $signed({1'b0, p2_i}) - $signed({1'b0, p1_i});
   assign prod_s = PROD_W'(diff_s) * $signed({{(PROD_W-FRAC_W){1'b0}}, frac_i});

`ifdef RESIZE_ROUND_EN
   localparam logic [PROD_W-1:0] HALF_LSB = {{(PROD_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
   assign adj_s = prod_s + $signed(HALF_LSB);
`else
   assign adj_s = prod_s;
`endif

   // The result is bounded by p1 and p2, so the upper bits of the sum carry no information.
   assign shifted_s   = adj_s >>> FRAC_W;
   assign sum_s       = $signed({{(PROD_W-DATA_W){1'b0}}, p1_i}) + shifted_s;
   assign result_o    = sum_s[DATA_W-1:0];
   assign unused_hi_s = ^sum_s[PROD_W-1:DATA_W];

endmodule

// File: rtl/resize_interp_engine.sv
// Reads two source pixels per request, interpolates them and writes one pixel every 6 cycles.
// Rounding mode is selected by the RESIZE_ROUND_EN macro inside the lerp sub-module.
module resize_interp_engine
   import resize_interp_engine_pkg::*;
(
   input  logic                              clk_i,
   input  logic                              reset_i,
   resize_interp_engine_if.req_slave         req_if,
   resize_interp_engine_if.ram_master        ram_if,
   input  logic                              ctrl_done_i,
   output logic                              busy_o,
   output logic                              done_o
);

   state_e             state_q;
   req_t               req_q;
   logic [DATA_W-1:0]  p1_q;
   logic [DATA_W-1:0]  p2_q;
   logic [DATA_W-1:0]  result_d;
   logic               req_ready_q;
   logic               rd_en_q;
   logic [ADDR_SZ-1:0] rd_addr_q;
   logic               wr_en_q;
   logic [ADDR_SZ-1:0] wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic               wr_stage_q;
   logic               busy_q;
   logic               done_q;
   logic               done_pending_q;
   logic               done_pending_d;
   logic               done_fire_s;
   logic               accept_s;

   resize_interp_engine_lerp u_lerp (
      .p1_i     (p1_q),
      .p2_i     (p2_q),
      .frac_i   (req_q.frac),
      .result_o (result_d)
   );

   assign accept_s = req_if.req_valid & req_ready_q;

   // Completion is held back while a request is waiting so done always trails the last write.
   always_comb begin
      done_fire_s    = 1'b0;
      done_pending_d = done_pending_q;
      if ((state_q == ST_IDLE) && done_pending_q && !req_if.req_valid) begin
         done_fire_s = 1'b1;
      end else begin
         done_fire_s = 1'b0;
      end
      done_pending_d = ctrl_done_i | (done_pending_q & ~done_fire_s);
   end

   // Engine FSM; every output is registered on the transition into the state that owns it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= ST_IDLE;
         req_q          <= '0;
         p1_q           <= '0;
         p2_q           <= '0;
         req_ready_q    <= 1'b1;
         rd_en_q        <= 1'b0;
         rd_addr_q      <= '0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         wr_stage_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         done_pending_q <= 1'b0;
      end else begin
         rd_en_q        <= 1'b0;
         wr_en_q        <= 1'b0;
         done_q         <= done_fire_s;
         done_pending_q <= done_pending_d;
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  req_q       <= '{src_addr1: req_if.src_addr1, src_addr2: req_if.src_addr2,
                                   des_addr: req_if.des_addr, frac: req_if.fraction_part,
                                   stage: req_if.stage_flag};
                  rd_en_q     <= 1'b1;
                  rd_addr_q   <= req_if.src_addr1;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_RD1;
               end
            end
            ST_RD1: begin
               rd_en_q   <= 1'b1;
               rd_addr_q <= req_q.src_addr2;
               state_q   <= ST_RD2;
            end
            ST_RD2: begin
               p1_q    <= ram_if.rd_data;
               state_q <= ST_CAP;
            end
            ST_CAP: begin
               p2_q    <= ram_if.rd_data;
               state_q <= ST_CALC;
            end
            ST_CALC: begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= req_q.des_addr;
               wr_data_q  <= result_d;
               wr_stage_q <= req_q.stage;
               state_q    <= ST_WR;
            end
            ST_WR: begin
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: begin
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_if.req_ready = req_ready_q;
   assign ram_if.rd_en     = rd_en_q;
   assign ram_if.rd_addr   = rd_addr_q;
   assign ram_if.wr_en     = wr_en_q;
   assign ram_if.wr_addr   = wr_addr_q;
   assign ram_if.wr_data   = wr_data_q;
   assign ram_if.wr_stage  = wr_stage_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;

endmodule

// File: tb/tb_resize_interp_engine.sv
// Scoreboard bench for resize_interp_engine: a RAM model feeds reads, expected writes are queued at acceptance.
module tb_resize_interp_engine;
   import resize_interp_engine_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ctrl_done = 1'b0;
   logic busy;
   logic done;

   resize_interp_engine_if bus();

   resize_interp_engine dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_if      (bus.req_slave),
      .ram_if      (bus.ram_master),
      .ctrl_done_i (ctrl_done),
      .busy_o      (busy),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:65535];
   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int last_wr_cyc = -1;
   logic [15:0] last_wr_data = 16'd0;

   typedef struct {logic [15:0] addr; logic [15:0] data; logic stage; int cyc;} wr_exp_t;
   typedef struct {logic [15:0] addr; int cyc;} rd_exp_t;
   wr_exp_t wq[$];
   rd_exp_t rq[$];
   int acc_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference lerp written as explicit floor division of the weighted difference.
   function automatic logic [15:0] model(input logic [15:0] p1, input logic [15:0] p2, input logic [15:0] frac);
      longint num;
      longint q;
      num = (longint'(p2) - longint'(p1)) * longint'(frac);
`ifdef RESIZE_ROUND_EN
      num = num + 64'sd32768;
`endif
      if (num >= 0) q = num / 65536;
      else          q = -((-num + 65535) / 65536);
      return 16'(longint'(p1) + q);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   // Acceptance: queue expected reads and the expected write with their cycle stamps.
   always @(posedge clk) begin
      if (!reset && bus.req_valid && bus.req_ready) begin
         rq.push_back('{bus.src_addr1, cyc + 1});
         rq.push_back('{bus.src_addr2, cyc + 2});
         wq.push_back('{bus.des_addr, model(mem[bus.src_addr1], mem[bus.src_addr2], bus.fraction_part),
                        bus.stage_flag, cyc + 5});
         acc_q.push_back(cyc);
      end
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      rd_exp_t r;
      wr_exp_t w;
      if (!reset) begin
         if (bus.rd_en) begin
            if (rq.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
            else begin
               r = rq.pop_front();
               check("rd_addr", bus.rd_addr, r.addr);
               check("rd_cycle", cyc, r.cyc);
            end
         end
         if (bus.wr_en) begin
            check("wr_rd_exclusive", bus.rd_en, 64'd0);
            last_wr_cyc  = cyc;
            last_wr_data = bus.wr_data;
            if (wq.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
            else begin
               w = wq.pop_front();
               check("wr_addr", bus.wr_addr, w.addr);
               check("wr_data", bus.wr_data, w.data);
               check("wr_stage", bus.wr_stage, w.stage);
               check("wr_cycle", cyc, w.cyc);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_wr_exclusive", bus.wr_en, 64'd0);
         end
      end
   end

   task automatic send(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] da,
                       input logic [15:0] frac, input logic stg, input logic cd, input logic keep);
      int n;
      @(negedge clk);
      bus.req_valid     = 1'b1;
      bus.src_addr1     = a1;
      bus.src_addr2     = a2;
      bus.des_addr      = da;
      bus.fraction_part = frac;
      bus.stage_flag    = stg;
      ctrl_done         = cd;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", bus.req_ready, 64'd1);
      @(posedge clk);
      #1;
      if (!keep) begin
         bus.req_valid = 1'b0;
         ctrl_done     = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (wq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain", wq.size(), 64'd0);
   endtask

   task automatic reset_outputs(input string tag);
      check({tag, "_req_ready"}, bus.req_ready, 64'd1);
      check({tag, "_rd_en"}, bus.rd_en, 64'd0);
      check({tag, "_wr_en"}, bus.wr_en, 64'd0);
      check({tag, "_busy"}, busy, 64'd0);
      check({tag, "_done"}, done, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] rd;
      bus.req_valid     = 1'b0;
      bus.src_addr1     = 16'd0;
      bus.src_addr2     = 16'd0;
      bus.des_addr      = 16'd0;
      bus.fraction_part = 16'd0;
      bus.stage_flag    = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7);
      mem[16'h0010] = 16'd100;   mem[16'h0011] = 16'd200;
      mem[16'h0020] = 16'd77;    mem[16'h0021] = 16'd999;
      mem[16'h0030] = 16'd200;   mem[16'h0031] = 16'd100;
      mem[16'h0040] = 16'd0;     mem[16'h0041] = 16'd3;
      mem[16'h0050] = 16'd500;
      mem[16'h0060] = 16'd0;     mem[16'h0061] = 16'hFFFF;

      repeat (3) @(negedge clk);
      reset_outputs("reset");
      reset = 1'b0;

      send(16'h0010, 16'h0011, 16'h0100, 16'h8000, 1'b0, 1'b0, 1'b0);
      drain();
      check("mid_value", last_wr_data, 64'd150);

      send(16'h0020, 16'h0021, 16'h0101, 16'h0000, 1'b1, 1'b0, 1'b0);
      drain();
      check("frac_zero", last_wr_data, 64'd77);

      send(16'h0030, 16'h0031, 16'h0102, 16'h4000, 1'b0, 1'b0, 1'b0);
      drain();
      check("decreasing", last_wr_data, 64'd175);

      send(16'h0040, 16'h0041, 16'h0103, 16'h5555, 1'b0, 1'b0, 1'b0);
      drain();
`ifdef RESIZE_ROUND_EN
      check("round_mode", last_wr_data, 64'd1);
`else
      check("round_mode", last_wr_data, 64'd0);
`endif

      send(16'h0050, 16'h0050, 16'h0104, 16'h1234, 1'b1, 1'b0, 1'b0);
      drain();
      check("same_addr", last_wr_data, 64'd500);

      send(16'h0060, 16'h0061, 16'h0105, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      drain();

      for (int k = 0; k < 6; k++) begin
         ra = 16'($urandom_range(16'h1000, 16'h1FFF));
         rb = 16'($urandom_range(16'h2000, 16'h2FFF));
         rd = 16'($urandom_range(16'h3000, 16'h3FFF));
         mem[ra] = 16'($urandom);
         mem[rb] = 16'($urandom);
         send(ra, rb, rd, 16'($urandom), 1'($urandom), 1'b0, 1'b0);
         drain();
      end
      check("no_stray_done", done_cnt, 64'd0);

      acc_q.delete();
      send(16'h0010, 16'h0031, 16'h0200, 16'h2000, 1'b0, 1'b0, 1'b1);
      send(16'h0021, 16'h0040, 16'h0201, 16'hC000, 1'b1, 1'b0, 1'b1);
      send(16'h0030, 16'h0061, 16'h0202, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      drain();
      repeat (15) @(negedge clk);
      check("b2b_accepts", acc_q.size(), 64'd3);
      if (acc_q.size() == 3) begin
         check("b2b_gap1", acc_q[1] - acc_q[0], 64'd6);
         check("b2b_gap2", acc_q[2] - acc_q[1], 64'd6);
      end
      check("done_count", done_cnt, 64'd1);
      check("done_after_wr", (done_cyc > last_wr_cyc) ? 1 : 0, 64'd1);

      send(16'h0010, 16'h0011, 16'h0300, 16'h8000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      wq.delete();
      rq.delete();
      @(negedge clk);
      reset = 1'b0;
      reset_outputs("mid_reset");
      repeat (8) @(negedge clk);

      send(16'h0030, 16'h0031, 16'h0301, 16'h4000, 1'b1, 1'b0, 1'b0);
      drain();
      check("after_reset", last_wr_data, 64'd175);
      check("reads_drained", rq.size(), 64'd0);
      check("final_done_count", done_cnt, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
